// File: rtl/dual_issue_hazard_ctrl_pkg.sv
// Shared types and constants for the dual-issue hazard controller.
// Optional performance counters are enabled with DUAL_HAZ_PERF_CNT_EN.
package dual_issue_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Decoded-slot descriptor as seen by the dependency checker
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rt;
    logic [REG_W-1:0] dst;
    logic             reg_write;
    logic             mem;
    logic             branch;
  } slot_t;

  // True when a non-zero register matches one of the slot's valid sources
  function automatic logic src_hit(input logic [REG_W-1:0] dst, input slot_t s);
    return (dst != REG_ZERO) && ((s.rs == dst) || (s.use_rt && (s.rt == dst)));
  endfunction

endpackage

// File: rtl/dual_issue_hazard_ctrl_if.sv
// Decode/EX hazard inputs and pipeline control outputs of the dual-issue hazard controller.
interface dual_issue_hazard_ctrl_if;
  import dual_issue_hazard_ctrl_pkg::*;

  logic             valid_D0, valid_D1;
  logic [REG_W-1:0] rs_D0, rt_D0, rs_D1, rt_D1;
  logic             useRt_D0, useRt_D1;
  logic [REG_W-1:0] dst_D0, dst_D1;
  logic             regWrite_D0, regWrite_D1;
  logic             mem_D0, mem_D1;
  logic             branch_D0, branch_D1;
  logic             predTaken_D0;
  logic             memRead_E0, memRead_E1;
  logic [REG_W-1:0] dst_E0, dst_E1;
  logic             mispredict_E;

  logic             stallF, stallD, flushFD;
  logic             flush_D_0, flush_D_1;
  logic             split_pending;
  logic [CNT_W-1:0] cnt_split, cnt_lu, cnt_flush;

  modport master (
    output valid_D0, valid_D1, rs_D0, rt_D0, rs_D1, rt_D1, useRt_D0, useRt_D1,
           dst_D0, dst_D1, regWrite_D0, regWrite_D1, mem_D0, mem_D1,
           branch_D0, branch_D1, predTaken_D0, memRead_E0, memRead_E1,
           dst_E0, dst_E1, mispredict_E,
    input  stallF, stallD, flushFD, flush_D_0, flush_D_1, split_pending,
           cnt_split, cnt_lu, cnt_flush
  );

  modport slave (
    input  valid_D0, valid_D1, rs_D0, rt_D0, rs_D1, rt_D1, useRt_D0, useRt_D1,
           dst_D0, dst_D1, regWrite_D0, regWrite_D1, mem_D0, mem_D1,
           branch_D0, branch_D1, predTaken_D0, memRead_E0, memRead_E1,
           dst_E0, dst_E1, mispredict_E,
    output stallF, stallD, flushFD, flush_D_0, flush_D_1, split_pending,
           cnt_split, cnt_lu, cnt_flush
  );

endinterface

// File: rtl/dual_issue_hazard_ctrl_dep_check.sv
// Intra-pair dependency checker: decides whether a decoded pair must be split.
module dual_issue_dep_check
  import dual_issue_hazard_ctrl_pkg::*;
(
  input  slot_t d0,
  input  slot_t d1,
  output logic  raw,
  output logic  waw,
  output logic  memConflict,
  output logic  brConflict,
  output logic  splitCond
);

  always_comb begin
    raw         = d0.reg_write && src_hit(d0.dst, d1);
    waw         = d0.reg_write && d1.reg_write && (d0.dst == d1.dst) && (d0.dst != REG_ZERO);
    memConflict = d0.mem && d1.mem;
    brConflict  = d0.branch && d1.branch;
    splitCond   = d0.valid && d1.valid && (raw || waw || memConflict || brConflict);
  end

endmodule

// File: rtl/dual_issue_hazard_ctrl.sv
// Issue/hazard controller: pair FSM, priority mux for stall/flush, optional counters.
// Counters are built only when DUAL_HAZ_PERF_CNT_EN is defined.
module dual_issue_hazard_ctrl
  import dual_issue_hazard_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  dual_issue_hazard_ctrl_if.slave  bus
);

  state_e state, state_nxt;
  slot_t  d0, d1;
  logic   raw, waw, mem_conflict, br_conflict, split_cond;
  logic   dep_unused;
  logic   lu_c;
  logic   stall_f_c, stall_d_c, flush_fd_c, flush_d0_c, flush_d1_c;
  logic   lu_evt_c, flush_evt_c, split_evt_c;

  always_comb begin
    d0.valid     = bus.valid_D0;
    d0.rs        = bus.rs_D0;
    d0.rt        = bus.rt_D0;
    d0.use_rt    = bus.useRt_D0;
    d0.dst       = bus.dst_D0;
    d0.reg_write = bus.regWrite_D0;
    d0.mem       = bus.mem_D0;
    d0.branch    = bus.branch_D0;
    d1.valid     = bus.valid_D1;
    d1.rs        = bus.rs_D1;
    d1.rt        = bus.rt_D1;
    d1.use_rt    = bus.useRt_D1;
    d1.dst       = bus.dst_D1;
    d1.reg_write = bus.regWrite_D1;
    d1.mem       = bus.mem_D1;
    d1.branch    = bus.branch_D1;
  end

  dual_issue_dep_check u_dep (
    .d0          (d0),
    .d1          (d1),
    .raw         (raw),
    .waw         (waw),
    .memConflict (mem_conflict),
    .brConflict  (br_conflict),
    .splitCond   (split_cond)
  );

  // Individual conflict flags are kept for observability; only splitCond steers the FSM
  assign dep_unused = raw ^ waw ^ mem_conflict ^ br_conflict;

  // In SPLIT slot 0 has already left decode, so only slot-1 sources can be exposed
  always_comb begin
    lu_c = (bus.memRead_E0 && (src_hit(bus.dst_E0, d1) || ((state == ST_PAIR) && src_hit(bus.dst_E0, d0))))
        || (bus.memRead_E1 && (src_hit(bus.dst_E1, d1) || ((state == ST_PAIR) && src_hit(bus.dst_E1, d0))));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_PAIR;
    else        state <= state_nxt;
  end

  // Priority mux: mispredict > load-use > pair handling > split completion
  always_comb begin
    state_nxt  = state;
    stall_f_c  = 1'b0;
    stall_d_c  = 1'b0;
    flush_fd_c = 1'b0;
    flush_d0_c = 1'b0;
    flush_d1_c = 1'b0;
    if (!reset) begin
      state_nxt = ST_PAIR;
    end else if (bus.mispredict_E) begin
      flush_fd_c = 1'b1;
      flush_d0_c = 1'b1;
      flush_d1_c = 1'b1;
      state_nxt  = ST_PAIR;
    end else if (lu_c) begin
      stall_f_c  = 1'b1;
      stall_d_c  = 1'b1;
      flush_d0_c = 1'b1;
      flush_d1_c = 1'b1;
    end else if (state == ST_PAIR) begin
      flush_d0_c = !bus.valid_D0;
      if (bus.branch_D0 && bus.predTaken_D0) begin
        flush_d1_c = 1'b1;
      end else if (split_cond) begin
        stall_f_c  = 1'b1;
        stall_d_c  = 1'b1;
        flush_d1_c = 1'b1;
        state_nxt  = ST_SPLIT;
      end else if (!bus.valid_D1) begin
        flush_d1_c = 1'b1;
      end
    end else begin
      flush_d0_c = 1'b1;
      state_nxt  = ST_PAIR;
    end
  end

  assign bus.stallF        = stall_f_c;
  assign bus.stallD        = stall_d_c;
  assign bus.flushFD       = flush_fd_c;
  assign bus.flush_D_0     = flush_d0_c;
  assign bus.flush_D_1     = flush_d1_c;
  assign bus.split_pending = reset && (state == ST_SPLIT);

  assign lu_evt_c    = reset && !bus.mispredict_E && lu_c;
  assign flush_evt_c = reset && bus.mispredict_E;
  assign split_evt_c = (state == ST_PAIR) && (state_nxt == ST_SPLIT);

`ifdef DUAL_HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_split_q, cnt_lu_q, cnt_flush_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_split_q <= '0;
      cnt_lu_q    <= '0;
      cnt_flush_q <= '0;
    end else begin
      if (split_evt_c && (cnt_split_q != CNT_MAX)) cnt_split_q <= cnt_split_q + CNT_W'(1);
      if (lu_evt_c    && (cnt_lu_q    != CNT_MAX)) cnt_lu_q    <= cnt_lu_q    + CNT_W'(1);
      if (flush_evt_c && (cnt_flush_q != CNT_MAX)) cnt_flush_q <= cnt_flush_q + CNT_W'(1);
    end
  end

  assign bus.cnt_split = reset ? cnt_split_q : '0;
  assign bus.cnt_lu    = reset ? cnt_lu_q    : '0;
  assign bus.cnt_flush = reset ? cnt_flush_q : '0;
`else
  logic evt_unused;
  assign evt_unused    = lu_evt_c ^ flush_evt_c ^ split_evt_c;
  assign bus.cnt_split = '0;
  assign bus.cnt_lu    = '0;
  assign bus.cnt_flush = '0;
`endif

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// Bench for dual_issue_hazard_ctrl: directed scenarios plus randomized pairs against a rule-level model.
module tb_dual_issue_hazard_ctrl;
  import dual_issue_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   run_chk = 1'b0;

  always #5 clk = ~clk;

  dual_issue_hazard_ctrl_if bus ();

  dual_issue_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit stallF, stallD, flushFD, fd0, fd1, split_pending, nxt_split, lu;
  } exp_t;

  bit m_split;
  int m_cnt_split, m_cnt_lu, m_cnt_flush;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Rule-level model: source lists, hazard predicates, then first-match priority
  function automatic exp_t model();
    exp_t e;
    int s0[$], s1[$], act[$];
    bit split;
    e = '{default: 1'b0};
    e.nxt_split = m_split;
    if (reset !== 1'b1) begin
      e.nxt_split = 1'b0;
      return e;
    end
    e.split_pending = m_split;
    if (bus.rs_D0 != 0) s0.push_back(int'(bus.rs_D0));
    if (bus.useRt_D0 && bus.rt_D0 != 0) s0.push_back(int'(bus.rt_D0));
    if (bus.rs_D1 != 0) s1.push_back(int'(bus.rs_D1));
    if (bus.useRt_D1 && bus.rt_D1 != 0) s1.push_back(int'(bus.rt_D1));
    if (!m_split) foreach (s0[i]) act.push_back(s0[i]);
    foreach (s1[i]) act.push_back(s1[i]);
    e.lu = (bus.memRead_E0 && bus.dst_E0 != 0 && in_q(act, int'(bus.dst_E0)))
        || (bus.memRead_E1 && bus.dst_E1 != 0 && in_q(act, int'(bus.dst_E1)));
    split = bus.valid_D0 && bus.valid_D1 && (
              (bus.regWrite_D0 && bus.dst_D0 != 0 && in_q(s1, int'(bus.dst_D0)))
           || (bus.regWrite_D0 && bus.regWrite_D1 && bus.dst_D0 == bus.dst_D1 && bus.dst_D0 != 0)
           || (bus.mem_D0 && bus.mem_D1)
           || (bus.branch_D0 && bus.branch_D1));
    if (bus.mispredict_E) begin
      e.flushFD = 1; e.fd0 = 1; e.fd1 = 1; e.nxt_split = 0;
    end else if (e.lu) begin
      e.stallF = 1; e.stallD = 1; e.fd0 = 1; e.fd1 = 1;
    end else if (!m_split) begin
      e.fd0 = !bus.valid_D0;
      if (bus.branch_D0 && bus.predTaken_D0) e.fd1 = 1;
      else if (split) begin
        e.stallF = 1; e.stallD = 1; e.fd1 = 1; e.nxt_split = 1;
      end else if (!bus.valid_D1) e.fd1 = 1;
    end else begin
      e.fd0 = 1; e.nxt_split = 0;
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin : model_upd
    exp_t e;
    if (!reset) begin
      m_split     <= 1'b0;
      m_cnt_split <= 0;
      m_cnt_lu    <= 0;
      m_cnt_flush <= 0;
    end else begin
      e = model();
      m_split <= e.nxt_split;
      if (!m_split && e.nxt_split && m_cnt_split < CNT_SAT) m_cnt_split <= m_cnt_split + 1;
      if (!bus.mispredict_E && e.lu && m_cnt_lu < CNT_SAT)  m_cnt_lu    <= m_cnt_lu + 1;
      if (bus.mispredict_E && m_cnt_flush < CNT_SAT)        m_cnt_flush <= m_cnt_flush + 1;
    end
  end

  task automatic cmp_all(input string tag);
    exp_t e;
    int es, el, ef;
    e = model();
`ifdef DUAL_HAZ_PERF_CNT_EN
    es = (reset === 1'b1) ? m_cnt_split : 0;
    el = (reset === 1'b1) ? m_cnt_lu    : 0;
    ef = (reset === 1'b1) ? m_cnt_flush : 0;
`else
    es = 0; el = 0; ef = 0;
`endif
    chk({tag, ".stallF"},        32'(bus.stallF),        32'(e.stallF));
    chk({tag, ".stallD"},        32'(bus.stallD),        32'(e.stallD));
    chk({tag, ".flushFD"},       32'(bus.flushFD),       32'(e.flushFD));
    chk({tag, ".flush_D_0"},     32'(bus.flush_D_0),     32'(e.fd0));
    chk({tag, ".flush_D_1"},     32'(bus.flush_D_1),     32'(e.fd1));
    chk({tag, ".split_pending"}, 32'(bus.split_pending), 32'(e.split_pending));
    chk({tag, ".cnt_split"},     32'(bus.cnt_split),     32'(es));
    chk({tag, ".cnt_lu"},        32'(bus.cnt_lu),        32'(el));
    chk({tag, ".cnt_flush"},     32'(bus.cnt_flush),     32'(ef));
  endtask

  always @(negedge clk) if (run_chk) cmp_all("model");

  // Hand-computed expectation of {stallF,stallD,flushFD,flush_D_0,flush_D_1,split_pending}
  task automatic lit(input string name, input logic [5:0] exp);
    chk(name, 32'({bus.stallF, bus.stallD, bus.flushFD, bus.flush_D_0, bus.flush_D_1, bus.split_pending}),
        32'(exp));
  endtask

  task automatic clear_in();
    bus.valid_D0 = 1; bus.valid_D1 = 1;
    bus.rs_D0 = '0; bus.rt_D0 = '0; bus.rs_D1 = '0; bus.rt_D1 = '0;
    bus.useRt_D0 = 0; bus.useRt_D1 = 0;
    bus.dst_D0 = '0; bus.dst_D1 = '0;
    bus.regWrite_D0 = 0; bus.regWrite_D1 = 0;
    bus.mem_D0 = 0; bus.mem_D1 = 0;
    bus.branch_D0 = 0; bus.branch_D1 = 0; bus.predTaken_D0 = 0;
    bus.memRead_E0 = 0; bus.memRead_E1 = 0;
    bus.dst_E0 = '0; bus.dst_E1 = '0;
    bus.mispredict_E = 0;
  endtask

  // add $a,$x,$y in slot 0 and add $b,$p,$q in slot 1
  task automatic set_alu(input int a, input int x, input int y, input int b, input int p, input int q);
    clear_in();
    bus.dst_D0 = REG_W'(a); bus.rs_D0 = REG_W'(x); bus.rt_D0 = REG_W'(y);
    bus.useRt_D0 = 1; bus.regWrite_D0 = 1;
    bus.dst_D1 = REG_W'(b); bus.rs_D1 = REG_W'(p); bus.rt_D1 = REG_W'(q);
    bus.useRt_D1 = 1; bus.regWrite_D1 = 1;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    bus.valid_D0     = ($urandom_range(0, 99) < 88);
    bus.valid_D1     = ($urandom_range(0, 99) < 80);
    bus.rs_D0        = REG_W'($urandom_range(0, 7));
    bus.rt_D0        = REG_W'($urandom_range(0, 7));
    bus.rs_D1        = REG_W'($urandom_range(0, 7));
    bus.rt_D1        = REG_W'($urandom_range(0, 7));
    bus.useRt_D0     = 1'($urandom_range(0, 1));
    bus.useRt_D1     = 1'($urandom_range(0, 1));
    bus.dst_D0       = REG_W'($urandom_range(0, 7));
    bus.dst_D1       = REG_W'($urandom_range(0, 7));
    bus.regWrite_D0  = ($urandom_range(0, 99) < 70);
    bus.regWrite_D1  = ($urandom_range(0, 99) < 70);
    bus.mem_D0       = ($urandom_range(0, 99) < 25);
    bus.mem_D1       = ($urandom_range(0, 99) < 25);
    bus.branch_D0    = ($urandom_range(0, 99) < 15);
    bus.branch_D1    = ($urandom_range(0, 99) < 15);
    bus.predTaken_D0 = 1'($urandom_range(0, 1));
    bus.memRead_E0   = ($urandom_range(0, 99) < 20);
    bus.memRead_E1   = ($urandom_range(0, 99) < 20);
    bus.dst_E0       = REG_W'($urandom_range(0, 7));
    bus.dst_E1       = REG_W'($urandom_range(0, 7));
    bus.mispredict_E = ($urandom_range(0, 99) < 7);
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    run_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_outputs", 6'b000000);
    reset = 1'b1;

    // Independent pairs issue together, state stays PAIR
    for (int i = 0; i < 3; i++) begin
      set_alu(1, 4, 5, 2, 6, 7);
      #2 lit($sformatf("indep_%0d", i), 6'b000000);
      step();
    end

    // RAW pair: split, then issue slot 1, then back to PAIR
    set_alu(3, 1, 2, 4, 3, 5);
    #2 lit("raw_n", 6'b110010);
    step();
    #2 lit("raw_n1", 6'b000101);
`ifdef DUAL_HAZ_PERF_CNT_EN
    chk("cnt_split_after_raw", 32'(bus.cnt_split), 32'd1);
`endif
    step();
    set_alu(1, 4, 5, 2, 6, 7);
    #2 lit("raw_n2", 6'b000000);
    step();

    // Load-use on slot-0 rs, then resolved; zero destination never stalls
    set_alu(1, 7, 2, 2, 6, 5);
    bus.memRead_E1 = 1; bus.dst_E1 = REG_W'(7);
    #2 lit("lu_stall", 6'b110110);
    step();
    bus.memRead_E1 = 0; bus.dst_E1 = '0;
    #2 lit("lu_issue", 6'b000000);
    step();
    set_alu(1, 0, 2, 2, 6, 5);
    bus.memRead_E1 = 1; bus.dst_E1 = '0;
    #2 lit("lu_dst0", 6'b000000);
    step();

    // Mispredict while in SPLIT drops the held slot 1
    set_alu(3, 1, 2, 4, 3, 5);
    #2 lit("msp_split_enter", 6'b110010);
    step();
    bus.mispredict_E = 1;
    #2 lit("msp_in_split", 6'b001111);
    step();
    set_alu(1, 4, 5, 2, 6, 7);
    #2 lit("msp_after", 6'b000000);
    step();

    // Two stores split; predicted-taken slot-0 branch only squashes slot 1
    clear_in();
    bus.mem_D0 = 1; bus.mem_D1 = 1;
    bus.rs_D0 = REG_W'(1); bus.rs_D1 = REG_W'(2);
    #2 lit("two_stores", 6'b110010);
    step();
    #2 lit("two_stores_n1", 6'b000101);
    step();
    clear_in();
    bus.branch_D0 = 1; bus.predTaken_D0 = 1; bus.branch_D1 = 1;
    bus.rs_D0 = REG_W'(1); bus.rt_D0 = REG_W'(2); bus.useRt_D0 = 1;
    #2 lit("pred_taken", 6'b000010);
    step();
    clear_in();
    bus.valid_D1 = 0;
    #2 lit("slot1_invalid", 6'b000010);
    step();

    // Reset asserted in SPLIT: outputs drop immediately, PAIR afterwards
    set_alu(3, 1, 2, 4, 3, 5);
    step();
    reset = 1'b0;
    #1 lit("reset_in_split", 6'b000000);
`ifdef DUAL_HAZ_PERF_CNT_EN
    chk("cnt_split_reset", 32'(bus.cnt_split), 32'd0);
`endif
    step();
    reset = 1'b1;
    set_alu(1, 4, 5, 2, 6, 7);
    #2 lit("after_reset", 6'b000000);
    step();

    // Randomized pairs checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      step();
    end

    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_hazard_ctrl.md
Name: dual_issue_hazard_ctrl

Overview:
Issue and hazard controller for the dual-issue core. It sits beside the decode stage and drives the stall and flush inputs of the IF/ID register and of both ID/EX slot registers (slot 0 and slot 1). Each cycle it decides one of four outcomes:
- issue both instructions of the decoded pair;
- split the pair across two cycles;
- insert a load-use bubble;
- squash on a branch mispredict.

Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, performance-counter width (used only with the optional feature)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- valid_D0, valid_D1  in  1  decoded slot is a real instruction
- rs_D0, rt_D0, rs_D1, rt_D1  in  REG_W  source specifiers
- useRt_D0, useRt_D1  in  1  rt is read as a source
- dst_D0, dst_D1  in  REG_W  resolved destination (after RegDst)
- regWrite_D0, regWrite_D1  in  1  register-write enable
- mem_D0, mem_D1  in  1  load or store
- branch_D0, branch_D1  in  1  branch or jump
- predTaken_D0  in  1  slot-0 branch predicted taken
- memRead_E0, memRead_E1  in  1  EX-slot load
- dst_E0, dst_E1  in  REG_W  EX-slot destination
- mispredict_E  in  1  EX branch resolution says redirect
- stallF  out  1  hold PC
- stallD  out  1  hold IF/ID
- flushFD  out  1  clear IF/ID
- flush_D_0  out  1  bubble into ID/EX slot 0
- flush_D_1  out  1  bubble into ID/EX slot 1
- split_pending  out  1  FSM is in SPLIT
- cnt_split, cnt_lu, cnt_flush  out  CNT_W  performance counters

Behaviour:
Reset:
- reset low clears the state register to PAIR immediately.
- While reset is low, all outputs are forced to 0.
- Reset asserted mid-split abandons the held slot-1 instruction. Nothing is replayed.

Outputs are combinational from the registered state and the current-cycle inputs; the state register updates on the clock. Decision latency is zero cycles.

Definitions:
- A source is valid only when its specifier is non-zero, and rt only when useRt is 1.
- "Active sources": in PAIR, all valid sources of both slots; in SPLIT, slot-1 sources only.
- LU (load-use): for some k in {0,1}, memRead_Ek=1 and dst_Ek≠0 and dst_Ek equals an active source.
- SPLITCOND: valid_D0 & valid_D1 & any of:
  - RAW: regWrite_D0, dst_D0≠0, and dst_D0 equals a valid slot-1 source;
  - WAW: both regWrite, and dst_D0=dst_D1≠0;
  - single data-memory port: mem_D0 & mem_D1;
  - branch_D0 & branch_D1.

Priority, top to bottom; the first match wins.
1. mispredict_E: flushFD=1, flush_D_0=1, flush_D_1=1, no stall. Next state PAIR.
2. LU: stallF=1, stallD=1, flush_D_0=1, flush_D_1=1. State is held.
3. PAIR with branch_D0 & predTaken_D0: flush_D_1=1 (slot 1 is wrong-path), slot 0 issues. Next state PAIR.
4. PAIR with SPLITCOND: stallF=1, stallD=1, flush_D_1=1, slot 0 issues. Next state SPLIT.
5. PAIR with valid_D1=0: flush_D_1=1. Next state PAIR.
6. SPLIT: flush_D_0=1 (slot 0 was already issued), slot 1 issues, no stall. Next state PAIR.
7. Otherwise both slots issue and all outputs are 0.

Additional rules:
- valid_D0=0 in PAIR forces flush_D_0=1 but does not alone cause a split.
- split_pending = (state==SPLIT).
- A mispredict arriving while in SPLIT drops the held slot-1 instruction.

Optional Feature:
- Macro: DUAL_HAZ_PERF_CNT_EN.
- Defined: three CNT_W counters, saturating at all-ones and reset to 0.
  - cnt_split increments on each PAIR→SPLIT transition.
  - cnt_lu increments on each LU stall cycle.
  - cnt_flush increments on each mispredict cycle.
- Undefined: the counter outputs are tied to 0 and no counter flops are built.

Decomposition:
- Shared include dual_pkg.vh holds: the state encodings ST_PAIR=1'b0 and ST_SPLIT=1'b1, REG_W, and the zero-register constant REG_ZERO.
- Sub-module dual_issue_dep_check: purely combinational. It takes the two slot descriptors and produces raw, waw, memConflict, brConflict and splitCond.
- The top level holds the FSM, the priority mux and the counters.

Test Plan:
1. Independent pair (add $1 / add $2, no memory) → all outputs 0; state stays PAIR for 3 back-to-back pairs.
2. RAW pair, add $3,$1,$2 then sub $4,$3,$5:
   - cycle n: stallF=stallD=flush_D_1=1, split_pending becomes 1;
   - cycle n+1: flush_D_0=1, stalls 0;
   - cycle n+2: PAIR.
3. Load-use: memRead_E1=1, dst_E1=7, rs_D0=7 → one cycle with stallF=stallD=flush_D_0=flush_D_1=1; the pair issues the next cycle. Repeat with dst_E1=0 → no stall.
4. Mispredict during SPLIT: after step 2 cycle n, assert mispredict_E → flushFD and both flushes=1, state PAIR; slot 1 is never issued.
5. Two stores in a pair → split. Slot-0 predicted-taken beq → flush_D_1 only, no split.
6. Reset low asserted in SPLIT → outputs immediately 0; after release, state is PAIR. With DUAL_HAZ_PERF_CNT_EN, cnt_split=1 after step 2 and the counters read 0 after reset.
